// File: rtl/ahbl_matrix_pkg.sv
// Shared AHB-Lite bus-matrix constants, arbitration mode codes and index helpers.
package ahbl_matrix_pkg;

   localparam logic [1:0] TRN_IDLE   = 2'b00;
   localparam logic [1:0] TRN_BUSY   = 2'b01;
   localparam logic [1:0] TRN_NONSEQ = 2'b10;
   localparam logic [1:0] TRN_SEQ    = 2'b11;

   localparam logic [2:0] BRST_SINGLE = 3'b000;
   localparam logic [2:0] BRST_INCR   = 3'b001;
   localparam logic [2:0] BRST_WRAP4  = 3'b010;
   localparam logic [2:0] BRST_INCR4  = 3'b011;
   localparam logic [2:0] BRST_WRAP8  = 3'b100;
   localparam logic [2:0] BRST_INCR8  = 3'b101;
   localparam logic [2:0] BRST_WRAP16 = 3'b110;
   localparam logic [2:0] BRST_INCR16 = 3'b111;

   localparam logic RESP_OKAY  = 1'b0;
   localparam logic RESP_ERROR = 1'b1;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   localparam int MAX_MASTERS = 16;

   // Width of a master index; never below one bit so N=1 still has a register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [MAX_MASTERS-1:0] idx_to_oh(input logic [3:0] idx);
      return MAX_MASTERS'(1) << idx;
   endfunction

   function automatic logic [3:0] oh_to_idx(input logic [MAX_MASTERS-1:0] oh);
      logic [3:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
         if (oh[i]) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/ahbl_slave_port_if.sv
// Bundled master-request and slave-side signals of one bus-matrix slave port.
interface ahbl_slave_port_if #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
);
   logic [NUM_MASTERS-1:0]            m_addrsel;
   logic [NUM_MASTERS-1:0]            m_datasel;
   logic [NUM_MASTERS-1:0]            m_prevready;
   logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr;
   logic [NUM_MASTERS*2-1:0]          m_htrans;
   logic [NUM_MASTERS*3-1:0]          m_hsize;
   logic [NUM_MASTERS*3-1:0]          m_hburst;
   logic [NUM_MASTERS-1:0]            m_hwrite;
   logic [NUM_MASTERS-1:0]            m_hmastlock;
   logic [NUM_MASTERS-1:0]            m_burstxfer;
   logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata;
   logic [NUM_MASTERS-1:0]            m_addrready;
   logic [NUM_MASTERS-1:0]            m_dataready;
   logic [NUM_MASTERS-1:0]            m_hresp;

   logic                              s_hsel;
   logic [ADDR_WIDTH-1:0]             s_haddr;
   logic [1:0]                        s_htrans;
   logic [2:0]                        s_hsize;
   logic [2:0]                        s_hburst;
   logic                              s_hwrite;
   logic                              s_hmastlock;
   logic [DATA_WIDTH-1:0]             s_hwdata;
   logic                              s_hready;
   logic                              s_hreadyout;
   logic                              s_hresp;

   logic [NUM_MASTERS-1:0]            addr_owner_o;

   // Port side: the slave-port stage itself.
   modport slave (
      input  m_addrsel, m_datasel, m_prevready, m_haddr, m_htrans, m_hsize, m_hburst,
             m_hwrite, m_hmastlock, m_burstxfer, m_hwdata, s_hreadyout, s_hresp,
      output m_addrready, m_dataready, m_hresp, s_hsel, s_haddr, s_htrans, s_hsize,
             s_hburst, s_hwrite, s_hmastlock, s_hwdata, s_hready, addr_owner_o
   );

   // Environment side: master stages plus the attached slave.
   modport master (
      output m_addrsel, m_datasel, m_prevready, m_haddr, m_htrans, m_hsize, m_hburst,
             m_hwrite, m_hmastlock, m_burstxfer, m_hwdata, s_hreadyout, s_hresp,
      input  m_addrready, m_dataready, m_hresp, s_hsel, s_haddr, s_htrans, s_hsize,
             s_hburst, s_hwrite, s_hmastlock, s_hwdata, s_hready, addr_owner_o
   );
endinterface

// File: rtl/ahbl_port_arbiter.sv
// Address-phase arbiter: fixed priority or round-robin, with lock/burst hold.
module ahbl_port_arbiter
   import ahbl_matrix_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int ARB_MODE    = ARB_RR
) (
   input  logic                   HCLK,
   input  logic                   aresetn,
   input  logic                   advance,
   input  logic                   error,
   input  logic [NUM_MASTERS-1:0] addrsel,
   input  logic [NUM_MASTERS-1:0] hmastlock,
   input  logic [NUM_MASTERS-1:0] burstxfer,
   output logic [NUM_MASTERS-1:0] owner_oh,
   output logic                   owner_valid
);
   localparam int          IW = idx_width(NUM_MASTERS);
   localparam int unsigned NM = NUM_MASTERS;

   logic          hold_q;
   logic [IW-1:0] hold_idx_q;
   logic [IW-1:0] rr_ptr_q;

   logic          fp_found, rr_found;
   logic [IW-1:0] fp_idx, rr_idx, cand_idx;
   logic [IW-1:0] owner_idx;

   // Fixed priority: lowest-index requester.
   always_comb begin
      fp_found = 1'b0;
      fp_idx   = '0;
      for (int unsigned i = 0; i < NM; i++) begin
         if (!fp_found && addrsel[i]) begin
            fp_found = 1'b1;
            fp_idx   = IW'(i);
         end
      end
   end

   // Round-robin: first requester searching upward from rr_ptr_q+1, wrapping.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand_idx = '0;
      for (int unsigned k = 1; k <= NM; k++) begin
         cand_idx = IW'((32'(rr_ptr_q) + k) % NM);
         if (!rr_found && addrsel[cand_idx]) begin
            rr_found = 1'b1;
            rr_idx   = cand_idx;
         end
      end
   end

   // Owner selection: a live hold wins, otherwise the configured arbiter.
   always_comb begin
      if (hold_q && addrsel[hold_idx_q]) begin
         owner_valid = 1'b1;
         owner_idx   = hold_idx_q;
      end else if (ARB_MODE == ARB_FIXED) begin
         owner_valid = fp_found;
         owner_idx   = fp_idx;
      end else begin
         owner_valid = rr_found;
         owner_idx   = rr_idx;
      end
   end

   // One-hot owner vector, all-zero when nobody requests.
   always_comb begin
      owner_oh = '0;
      for (int unsigned i = 0; i < NM; i++) begin
         owner_oh[i] = owner_valid && (owner_idx == IW'(i));
      end
   end

   // Arbitration state advances only at an accepted address-phase boundary.
   always_ff @(posedge HCLK or negedge aresetn) begin
      if (!aresetn) begin
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
         rr_ptr_q   <= IW'(NM - 1);
      end else if (advance) begin
         if (owner_valid) rr_ptr_q <= owner_idx;
         hold_q     <= owner_valid && (hmastlock[owner_idx] || burstxfer[owner_idx]) && !error;
         hold_idx_q <= owner_idx;
      end
   end

endmodule

// File: rtl/ahbl_slave_port.sv
// Slave-side port stage: address mux, data-phase owner tracking, ready/resp routing.
module ahbl_slave_port
   import ahbl_matrix_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int ARB_MODE    = ARB_RR
) (
   input logic              HCLK,
   input logic              aresetn,
   ahbl_slave_port_if.slave bus
);
   localparam int unsigned NM = NUM_MASTERS;

   logic [NUM_MASTERS-1:0] owner_oh;
   logic                   owner_valid;
   logic [NUM_MASTERS-1:0] data_owner_q;
   logic                   error_q;

   logic [ADDR_WIDTH-1:0]  haddr;
   logic [1:0]             htrans;
   logic [2:0]             hsize, hburst;
   logic                   hwrite, hmastlock;
   logic [DATA_WIDTH-1:0]  hwdata;
   logic [NUM_MASTERS-1:0] addrready, dataready, hresp;

   ahbl_port_arbiter #(
      .NUM_MASTERS (NUM_MASTERS),
      .ARB_MODE    (ARB_MODE)
   ) u_arb (
      .HCLK        (HCLK),
      .aresetn     (aresetn),
      .advance     (bus.s_hreadyout),
      .error       (error_q),
      .addrsel     (bus.m_addrsel),
      .hmastlock   (bus.m_hmastlock),
      .burstxfer   (bus.m_burstxfer),
      .owner_oh    (owner_oh),
      .owner_valid (owner_valid)
   );

   // Data-phase owner and first-ERROR-cycle flag, both retired at the next ready.
   always_ff @(posedge HCLK or negedge aresetn) begin
      if (!aresetn) begin
         data_owner_q <= '0;
         error_q      <= 1'b0;
      end else if (bus.s_hreadyout) begin
         data_owner_q <= owner_oh;
         error_q      <= 1'b0;
      end else if (bus.s_hresp) begin
         error_q      <= 1'b1;
      end
   end

   // Address/control mux from the address owner; IDLE unless its previous phase completed.
   always_comb begin
      haddr     = '0;
      htrans    = TRN_IDLE;
      hsize     = '0;
      hburst    = '0;
      hwrite    = 1'b0;
      hmastlock = 1'b0;
      for (int unsigned i = 0; i < NM; i++) begin
         if (owner_oh[i]) begin
            haddr     = bus.m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            hsize     = bus.m_hsize[i*3 +: 3];
            hburst    = bus.m_hburst[i*3 +: 3];
            hwrite    = bus.m_hwrite[i];
            hmastlock = bus.m_hmastlock[i];
            if (bus.m_prevready[i] || bus.m_datasel[i]) htrans = bus.m_htrans[i*2 +: 2];
         end
      end
   end

   // Write data and response follow the registered data-phase owner.
   always_comb begin
      hwdata = '0;
      hresp  = '0;
      for (int unsigned i = 0; i < NM; i++) begin
         if (data_owner_q[i]) begin
            hwdata   = bus.m_hwdata[i*DATA_WIDTH +: DATA_WIDTH];
            hresp[i] = bus.s_hresp;
         end
      end
   end

   // Per-master ready: stall losers, pass slave ready to owners, idle masters see ready.
   always_comb begin
      addrready = '1;
      dataready = '1;
      for (int unsigned i = 0; i < NM; i++) begin
         if (bus.m_addrsel[i]) addrready[i] = owner_oh[i] && bus.s_hreadyout;
         if (bus.m_datasel[i]) dataready[i] = data_owner_q[i] && bus.s_hreadyout;
      end
   end

   assign bus.s_hsel       = owner_valid;
   assign bus.s_haddr      = haddr;
   assign bus.s_htrans     = htrans;
   assign bus.s_hsize      = hsize;
   assign bus.s_hburst     = hburst;
   assign bus.s_hwrite     = hwrite;
   assign bus.s_hmastlock  = hmastlock;
   assign bus.s_hwdata     = hwdata;
   assign bus.s_hready     = bus.s_hreadyout;
   assign bus.m_hresp      = hresp;
   assign bus.m_addrready  = addrready;
   assign bus.m_dataready  = dataready;
   assign bus.addr_owner_o = owner_oh;

endmodule

// File: tb/tb_ahbl_slave_port.sv
// Bench: round-robin and fixed-priority ports driven in parallel, checked against a behavioural model.
module tb_ahbl_slave_port;
   localparam int N = 4;

   logic HCLK = 1'b0;
   logic rstn = 1'b0;
   always #5 HCLK = ~HCLK;

   ahbl_slave_port_if #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
   ahbl_slave_port_if #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

   ahbl_slave_port #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1)) dut_rr (
      .HCLK(HCLK), .aresetn(rstn), .bus(ifa.slave));
   ahbl_slave_port #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut_fp (
      .HCLK(HCLK), .aresetn(rstn), .bus(ifb.slave));

   assign ifb.m_addrsel   = ifa.m_addrsel;
   assign ifb.m_datasel   = ifa.m_datasel;
   assign ifb.m_prevready = ifa.m_prevready;
   assign ifb.m_haddr     = ifa.m_haddr;
   assign ifb.m_htrans    = ifa.m_htrans;
   assign ifb.m_hsize     = ifa.m_hsize;
   assign ifb.m_hburst    = ifa.m_hburst;
   assign ifb.m_hwrite    = ifa.m_hwrite;
   assign ifb.m_hmastlock = ifa.m_hmastlock;
   assign ifb.m_burstxfer = ifa.m_burstxfer;
   assign ifb.m_hwdata    = ifa.m_hwdata;
   assign ifb.s_hreadyout = ifa.s_hreadyout;
   assign ifb.s_hresp     = ifa.s_hresp;

   // Stimulus as per-master arrays.
   logic [N-1:0] addrsel, datasel, prevready, hwrite, lock, burst;
   logic [31:0]  haddr[N];
   logic [31:0]  hwdata[N];
   logic [1:0]   htrans[N];
   logic [2:0]   hsize[N];
   logic [2:0]   hburst[N];
   logic         rdy, hresp;

   int tests = 0;
   int fails = 0;

   // Model state, index 0 = round-robin port, 1 = fixed-priority port.
   int last_g[2];
   int hold_who[2];
   int down[2];
   bit held[2];
   bit err[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply();
      ifa.m_addrsel   = addrsel;
      ifa.m_datasel   = datasel;
      ifa.m_prevready = prevready;
      ifa.m_hwrite    = hwrite;
      ifa.m_hmastlock = lock;
      ifa.m_burstxfer = burst;
      ifa.s_hreadyout = rdy;
      ifa.s_hresp     = hresp;
      for (int i = 0; i < N; i++) begin
         ifa.m_haddr[i*32 +: 32]  = haddr[i];
         ifa.m_hwdata[i*32 +: 32] = hwdata[i];
         ifa.m_htrans[i*2 +: 2]   = htrans[i];
         ifa.m_hsize[i*3 +: 3]    = hsize[i];
         ifa.m_hburst[i*3 +: 3]   = hburst[i];
      end
   endtask

   task automatic clr();
      addrsel = '0; datasel = '0; prevready = '1; hwrite = '0; lock = '0; burst = '0;
      rdy = 1'b1; hresp = 1'b0;
      for (int i = 0; i < N; i++) begin
         haddr[i]  = 32'h1000_0000 + 32'(i) * 32'h100;
         hwdata[i] = 32'hD000_0000 + 32'(i);
         htrans[i] = 2'b10;
         hsize[i]  = 3'd2;
         hburst[i] = 3'd0;
      end
   endtask

   task automatic mreset();
      for (int m = 0; m < 2; m++) begin
         last_g[m] = N - 1; hold_who[m] = 0; down[m] = -1; held[m] = 0; err[m] = 0;
      end
   endtask

   // Who owns the address phase: a still-requesting holder, else the arbitration rule.
   function automatic int mowner(input int m);
      if (held[m] && addrsel[hold_who[m]]) return hold_who[m];
      if (m == 1) begin
         for (int i = 0; i < N; i++) if (addrsel[i]) return i;
      end else begin
         for (int k = 1; k <= N; k++) if (addrsel[(last_g[m] + k) % N]) return (last_g[m] + k) % N;
      end
      return -1;
   endfunction

   task automatic advance();
      int o;
      if (!rstn) begin
         mreset();
         return;
      end
      for (int m = 0; m < 2; m++) begin
         if (rdy) begin
            o = mowner(m);
            if (o >= 0) begin
               last_g[m]   = o;
               hold_who[m] = o;
            end
            held[m] = (o >= 0) && (lock[o] || burst[o]) && !err[m];
            down[m] = o;
            err[m]  = 0;
         end else if (hresp) begin
            err[m] = 1;
         end
      end
   endtask

   task automatic compare(input int m);
      logic [N-1:0] a_own, a_ar, a_dr, a_hr, e_own, e_ar, e_dr, e_hr;
      logic         a_sel, a_rdy;
      logic [31:0]  a_addr, a_wd, e_addr, e_wd;
      logic [1:0]   a_tr, e_tr;
      logic [7:0]   a_ctl, e_ctl;
      int o, d;
      if (m == 0) begin
         a_own = ifa.addr_owner_o; a_ar = ifa.m_addrready; a_dr = ifa.m_dataready; a_hr = ifa.m_hresp;
         a_sel = ifa.s_hsel; a_rdy = ifa.s_hready; a_addr = ifa.s_haddr; a_wd = ifa.s_hwdata;
         a_tr = ifa.s_htrans; a_ctl = {ifa.s_hsize, ifa.s_hburst, ifa.s_hwrite, ifa.s_hmastlock};
      end else begin
         a_own = ifb.addr_owner_o; a_ar = ifb.m_addrready; a_dr = ifb.m_dataready; a_hr = ifb.m_hresp;
         a_sel = ifb.s_hsel; a_rdy = ifb.s_hready; a_addr = ifb.s_haddr; a_wd = ifb.s_hwdata;
         a_tr = ifb.s_htrans; a_ctl = {ifb.s_hsize, ifb.s_hburst, ifb.s_hwrite, ifb.s_hmastlock};
      end
      o = mowner(m);
      d = down[m];
      e_own = '0; e_addr = '0; e_tr = 2'b00; e_ctl = '0; e_wd = '0; e_hr = '0;
      if (o >= 0) begin
         e_own  = N'(1) << o;
         e_addr = haddr[o];
         e_ctl  = {hsize[o], hburst[o], hwrite[o], lock[o]};
         if (prevready[o] || datasel[o]) e_tr = htrans[o];
      end
      if (d >= 0) begin
         e_wd = hwdata[d];
         if (hresp) e_hr = N'(1) << d;
      end
      for (int i = 0; i < N; i++) begin
         e_ar[i] = addrsel[i] ? ((o == i) ? rdy : 1'b0) : 1'b1;
         e_dr[i] = datasel[i] ? ((d == i) ? rdy : 1'b0) : 1'b1;
      end
      chk($sformatf("owner[%0d]", m), 64'(a_own), 64'(e_own));
      chk($sformatf("hsel[%0d]", m), 64'(a_sel), 64'(o >= 0));
      chk($sformatf("haddr[%0d]", m), 64'(a_addr), 64'(e_addr));
      chk($sformatf("htrans[%0d]", m), 64'(a_tr), 64'(e_tr));
      chk($sformatf("ctrl[%0d]", m), 64'(a_ctl), 64'(e_ctl));
      chk($sformatf("hwdata[%0d]", m), 64'(a_wd), 64'(e_wd));
      chk($sformatf("hresp[%0d]", m), 64'(a_hr), 64'(e_hr));
      chk($sformatf("addrready[%0d]", m), 64'(a_ar), 64'(e_ar));
      chk($sformatf("dataready[%0d]", m), 64'(a_dr), 64'(e_dr));
      chk($sformatf("hready[%0d]", m), 64'(a_rdy), 64'(rdy));
   endtask

   // Compare at the falling edge, advance the model at the rising edge.
   initial begin
      mreset();
      forever begin
         @(negedge HCLK);
         if (!rstn) mreset();
         compare(0);
         compare(1);
         @(posedge HCLK);
         advance();
      end
   end

   task automatic cyc();
      @(posedge HCLK);
      #2;
   endtask

   task automatic peek();
      @(negedge HCLK);
      #1;
   endtask

   initial begin
      clr();
      apply();
      repeat (3) cyc();
      peek();
      chk("rst_owner", 64'(ifa.addr_owner_o), 64'h0);
      chk("rst_hsel", 64'(ifa.s_hsel), 64'h0);
      chk("rst_addrready", 64'(ifa.m_addrready), 64'hF);
      chk("rst_hresp", 64'(ifa.m_hresp), 64'h0);

      cyc(); rstn = 1'b1; apply();

      // Round-robin fairness with every master requesting.
      for (int k = 0; k < 5; k++) begin
         cyc(); clr(); addrsel = 4'b1111; apply();
         peek();
         chk($sformatf("rr_seq%0d", k), 64'(ifa.addr_owner_o), 64'(4'b0001 << (k % 4)));
         chk($sformatf("fp_all%0d", k), 64'(ifb.addr_owner_o), 64'h1);
      end

      // Fixed priority with masters 1 and 2.
      for (int k = 0; k < 3; k++) begin
         cyc(); clr(); addrsel = 4'b0110; apply();
         peek();
         chk("fp_owner", 64'(ifb.addr_owner_o), 64'h2);
         chk("fp_addrready", 64'(ifb.m_addrready), 64'hB);
      end

      // Locked hold by master 2 against a pending master 0.
      for (int k = 0; k < 4; k++) begin
         cyc(); clr();
         addrsel = (k == 0) ? 4'b0100 : (k == 3) ? 4'b0001 : 4'b0101;
         lock    = (k == 3) ? 4'b0000 : 4'b0100;
         apply();
         peek();
         chk($sformatf("lock_rr%0d", k), 64'(ifa.addr_owner_o), (k == 3) ? 64'h1 : 64'h4);
         chk($sformatf("lock_fp%0d", k), 64'(ifb.addr_owner_o), (k == 3) ? 64'h1 : 64'h4);
      end

      // Master 1 write with two wait states.
      cyc(); clr(); addrsel = 4'b0010; hwrite = 4'b0010; apply();
      peek();
      chk("ws_owner", 64'(ifa.addr_owner_o), 64'h2);
      for (int k = 0; k < 3; k++) begin
         cyc(); clr(); addrsel = 4'b0010; datasel = 4'b0010; hwrite = 4'b0010;
         hwdata[1] = 32'hCAFE_0001; rdy = (k == 2); apply();
         peek();
         chk($sformatf("ws_hwdata%0d", k), 64'(ifa.s_hwdata), 64'hCAFE_0001);
         chk($sformatf("ws_dataready%0d", k), 64'(ifa.m_dataready), (k == 2) ? 64'hF : 64'hD);
         chk($sformatf("ws_owner%0d", k), 64'(ifb.addr_owner_o), 64'h2);
      end

      // Burst from master 3 terminated by a two-cycle ERROR.
      for (int k = 0; k < 5; k++) begin
         cyc(); clr();
         addrsel = (k == 0) ? 4'b1000 : 4'b1001;
         burst   = 4'b1000;
         datasel = (k == 2 || k == 3) ? 4'b1000 : 4'b0000;
         rdy     = (k != 2);
         hresp   = (k == 2 || k == 3);
         apply();
         peek();
         if (k == 2 || k == 3) begin
            chk($sformatf("err_hresp_rr%0d", k), 64'(ifa.m_hresp), 64'h8);
            chk($sformatf("err_hresp_fp%0d", k), 64'(ifb.m_hresp), 64'h8);
         end
         chk($sformatf("err_owner_rr%0d", k), 64'(ifa.addr_owner_o), (k == 4) ? 64'h1 : 64'h8);
         chk($sformatf("err_owner_fp%0d", k), 64'(ifb.addr_owner_o), (k == 4) ? 64'h1 : 64'h8);
      end

      // Asynchronous reset during a master 1 data phase.
      cyc(); clr(); addrsel = 4'b0010; burst = 4'b0010; apply();
      cyc(); clr(); addrsel = 4'b0010; burst = 4'b0010; datasel = 4'b0010; rdy = 1'b0; hresp = 1'b1; apply();
      #1;
      chk("mid_hresp", 64'(ifa.m_hresp), 64'h2);
      rstn = 1'b0; addrsel = '0; datasel = '0; apply();
      #1;
      chk("arst_owner", 64'(ifa.addr_owner_o), 64'h0);
      chk("arst_hsel", 64'(ifa.s_hsel), 64'h0);
      chk("arst_hresp_rr", 64'(ifa.m_hresp), 64'h0);
      chk("arst_hresp_fp", 64'(ifb.m_hresp), 64'h0);
      cyc(); clr(); rstn = 1'b1; addrsel = 4'b1111; apply();
      peek();
      chk("post_rst_rr", 64'(ifa.addr_owner_o), 64'h1);
      chk("post_rst_fp", 64'(ifb.addr_owner_o), 64'h1);

      // Randomized traffic, including occasional resets.
      repeat (2000) begin
         cyc();
         rstn      = ($urandom_range(0, 199) != 0);
         addrsel   = N'($urandom);
         datasel   = N'($urandom);
         prevready = N'($urandom);
         hwrite    = N'($urandom);
         lock      = N'($urandom) & N'($urandom);
         burst     = N'($urandom) & N'($urandom);
         rdy       = ($urandom_range(0, 3) != 0);
         hresp     = ($urandom_range(0, 7) == 0);
         for (int i = 0; i < N; i++) begin
            haddr[i]  = $urandom;
            hwdata[i] = $urandom;
            htrans[i] = 2'($urandom);
            hsize[i]  = 3'($urandom);
            hburst[i] = 3'($urandom);
         end
         apply();
      end
      cyc();
      peek();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
